// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ISSUE      = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } arb_state_t;

   localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin picker: first request at or after ptr_i, wrapping to the lowest index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic [N-1:0]  mask;
   logic [N-1:0]  masked;
   logic [N-1:0]  sel;
   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr_i));
      end
      masked = req_i & mask;
      // Nothing at or above the pointer: fall back to the plain lowest-index request.
      sel    = (|masked) ? masked : req_i;
      idx    = '0;
      found  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel[i] && !found) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
      idx_o = idx;
      gnt_o = (en_i && (|req_i)) ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers.
// Optional packet lock (keep one producer until its req_last byte) when UART_ARB_LOCK_EN is defined.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IW     = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    tx_we,
   output logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_busy,
   output logic [IW-1:0]           grant_id,
   output logic                    arb_busy,
   output arb_state_t              dbg_state_o
);

   // Handshake: req_ready[i] is high only in an accepting IDLE cycle; a byte is consumed
   // exactly when req_valid[i] && req_ready[i] are both high at a rising edge.

   arb_state_t        state_q, state_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     ptr_q, ptr_d;

   logic [N_REQ-1:0]  arb_req;
   logic [N_REQ-1:0]  win_gnt;
   logic [IW-1:0]     win_idx;
   logic [IW-1:0]     ptr_next;
   logic [DATA_W-1:0] win_data;
   logic              arb_en;

`ifdef UART_ARB_LOCK_EN
   logic          lock_q, lock_d;
   logic [IW-1:0] owner_q, owner_d;

   // While locked only the owning producer may be granted.
   assign arb_req = lock_q ? (req_valid & ({{(N_REQ-1){1'b0}}, 1'b1} << owner_q)) : req_valid;
`else
   logic unused_last;

   assign unused_last = ^req_last;
   assign arb_req     = req_valid;
`endif

   // A frame left running across a reset still blocks grants through tx_busy.
   assign arb_en   = (state_q == IDLE) && !tx_busy && !rst;
   assign win_data = req_data[win_idx*DATA_W +: DATA_W];
   assign ptr_next = (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + IW'(1);

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr (
      .req_i (arb_req),
      .ptr_i (ptr_q),
      .en_i  (arb_en),
      .gnt_o (win_gnt),
      .idx_o (win_idx)
   );

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      req_ready = '0;
      tx_we     = 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_d    = lock_q;
      owner_d   = owner_q;
`endif
      case (state_q)
         IDLE: begin
            if (arb_en && (|arb_req)) begin
               req_ready = win_gnt;
               tx_data_d = win_data;
               grant_d   = win_idx;
               state_d   = ISSUE;
`ifdef UART_ARB_LOCK_EN
               if (req_last[win_idx]) begin
                  lock_d = 1'b0;
                  ptr_d  = ptr_next;
               end else begin
                  lock_d  = 1'b1;
                  owner_d = win_idx;
               end
`else
               ptr_d = ptr_next;
`endif
            end
         end
         ISSUE: begin
            tx_we   = 1'b1;
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (tx_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_data_q <= '0;
         grant_q   <= '0;
         ptr_q     <= '0;
`ifdef UART_ARB_LOCK_EN
         lock_q    <= 1'b0;
         owner_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
`ifdef UART_ARB_LOCK_EN
         lock_q    <= lock_d;
         owner_q   <= owner_d;
`endif
      end
   end

   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign arb_busy    = (state_q != IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, corner sequences, randomized producers.
module tb_uart_tx_arbiter;
   import uart_arb_pkg::*;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int IW    = 2;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_last, req_ready;
   logic [N*W-1:0]  req_data;
   logic            tx_we, tx_busy, arb_busy;
   logic [W-1:0]    tx_data;
   logic [IW-1:0]   grant_id;
   arb_state_t      dbg_state;

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_we       (tx_we),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait budget expired at %0t", name, $time);
   endtask

   // ---------------- producers and UART model state ----------------
   logic [W-1:0] pbuf  [N][DEPTH];
   logic         plast [N][DEPTH];
   int           phead [N];
   int           pcnt  [N];
   bit           drop_en;
   int           busy_cnt;
   int           frame_len;
   logic         we_snap;
   logic [N-1:0] acc_snap;

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (phead[i] < pcnt[i]) begin
            req_valid[i]       = drop_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            req_data[i*W +: W] = pbuf[i][phead[i]];
            req_last[i]        = plast[i][phead[i]];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*W +: W] = '0;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic clear_producers();
      for (int i = 0; i < N; i++) begin
         phead[i] = 0;
         pcnt[i]  = 0;
      end
      drive_inputs();
   endtask

   task automatic push_byte(input int r, input logic [W-1:0] d, input logic last);
      pbuf[r][pcnt[r]]  = d;
      plast[r][pcnt[r]] = last;
      pcnt[r]++;
      drive_inputs();
   endtask

   // One clock: consume accepted bytes, advance the UART busy model, re-drive inputs.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_snap[i] && phead[i] < pcnt[i]) phead[i]++;
      end
      if (we_snap) busy_cnt = frame_len;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt > 0);
      drive_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- reference model / scoreboard ----------------
   // phase_m: 0 channel free, 1 byte accepted (strobe due), 2 awaiting frame start, 3 frame running
   int           ptr_m, phase_m, owner_m, gid_m, last_win, acc_count;
   logic         lock_m;
   logic [W-1:0] data_m;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] sent_q[$];

   always @(negedge clk) begin
      int           w;
      int           idx;
      logic [N-1:0] elig;
      logic [N-1:0] exp_rdy;
      we_snap  = tx_we;
      acc_snap = req_ready;
      if (rst) begin
         chk("ready_in_reset", req_ready, '0);
         ptr_m = 0; phase_m = 0; lock_m = 1'b0; owner_m = 0; gid_m = 0; data_m = '0;
         exp_q.delete();
      end else begin
         elig = lock_m ? (req_valid & (N'(1) << owner_m)) : req_valid;
         w = -1;
         exp_rdy = '0;
         if (phase_m == 0 && !tx_busy) begin
            for (int k = 0; k < N; k++) begin
               idx = (ptr_m + k) % N;
               if (elig[idx] && w < 0) w = idx;
            end
         end
         if (w >= 0) exp_rdy[w] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         chk("tx_we", tx_we, phase_m == 1);
         chk("we_while_busy", tx_we & tx_busy, 1'b0);
         chk("arb_busy", arb_busy, phase_m != 0);
         chk("tx_data", tx_data, data_m);
         chk("grant_id", grant_id, gid_m);
         if (tx_we) begin
            sent_q.push_back(tx_data);
            if (exp_q.size() > 0) chk("strobe_data", tx_data, exp_q.pop_front());
            else chk("strobe_without_byte", tx_we, 1'b0);
         end
         case (phase_m)
            1: phase_m = 2;
            2: if (tx_busy) phase_m = 3;
            3: if (!tx_busy) phase_m = 0;
            default: ;
         endcase
         if (w >= 0) begin
            data_m = req_data[w*W +: W];
            exp_q.push_back(data_m);
            gid_m    = w;
            last_win = w;
            phase_m  = 1;
            acc_count++;
`ifdef UART_ARB_LOCK_EN
            if (req_last[w]) begin
               lock_m = 1'b0;
               ptr_m  = (w + 1) % N;
            end else begin
               lock_m  = 1'b1;
               owner_m = w;
            end
`else
            ptr_m = (w + 1) % N;
`endif
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_accept(input string name, input int budget);
      int start;
      bit got;
      start = acc_count;
      got   = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         tick();
         if (acc_count != start) got = 1'b1;
      end
      if (!got) timeout_fail(name);
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit got;
      got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         tick();
         if (phase_m == 0 && !tx_busy) got = 1'b1;
      end
      if (!got) timeout_fail(name);
   endtask

   task automatic wait_sent(input string name, input int n, input int budget);
      bit got;
      got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         tick();
         if (sent_q.size() >= n) got = 1'b1;
      end
      if (!got) timeout_fail(name);
   endtask

   function automatic bit all_drained();
      for (int i = 0; i < N; i++) begin
         if (phead[i] < pcnt[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // ---------------- stimulus ----------------
   typedef struct {
      logic [N-1:0] mask;
      logic [W-1:0] base;
      int           exp_w;
      logic [W-1:0] exp_d;
   } vec_t;

   vec_t         vecs[9];
   logic [W-1:0] exp_seq[5];
   bit           ok;

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
      busy_cnt = 0; frame_len = 100; drop_en = 1'b0; we_snap = 1'b0; acc_snap = '0;
      acc_count = 0; last_win = -1;
      clear_producers();

      // requester i presents base+i; winners follow pointer 0,3,0,1,0,1,2,1,3
      vecs[0] = '{4'b0100, 8'h51, 2, 8'h53};
      vecs[1] = '{4'b1011, 8'h10, 3, 8'h13};
      vecs[2] = '{4'b1001, 8'h20, 0, 8'h20};
      vecs[3] = '{4'b1000, 8'h30, 3, 8'h33};
      vecs[4] = '{4'b1001, 8'h40, 0, 8'h40};
      vecs[5] = '{4'b1111, 8'h50, 1, 8'h51};
      vecs[6] = '{4'b0011, 8'h60, 0, 8'h60};
      vecs[7] = '{4'b1101, 8'h70, 2, 8'h72};
      vecs[8] = '{4'b0101, 8'h80, 0, 8'h80};

      do_reset();
      chk("rst_tx_we", tx_we, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_arb_busy", arb_busy, 1'b0);
      chk("rst_state", dbg_state, IDLE);
      chk("rst_req_ready", req_ready, '0);

      // Table: single grant per vector, then losers withdraw.
      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < N; i++) begin
            if (vecs[v].mask[i]) push_byte(i, vecs[v].base + W'(i), 1'b1);
         end
         wait_accept("vec_accept", 20);
         chk("vec_winner", last_win, vecs[v].exp_w);
         chk("vec_tx_we", tx_we, 1'b1);
         chk("vec_tx_data", tx_data, vecs[v].exp_d);
         chk("vec_grant_id", grant_id, vecs[v].exp_w);
         clear_producers();
         wait_idle("vec_idle", 300);
      end

      // All four contend from pointer 0: strict A0..A3 order.
      do_reset();
      sent_q.delete();
      for (int i = 0; i < N; i++) push_byte(i, 8'hA0 + W'(i), 1'b1);
      wait_sent("all4_sent", 4, 600);
      wait_idle("all4_idle", 300);
      for (int k = 0; k < 4; k++) begin
         if (k < sent_q.size()) chk("all4_order", sent_q[k], 8'hA0 + W'(k));
      end
      chk("all4_count", sent_q.size(), 4);

      // Reset while a frame runs: pointer cleared, grants held off until the frame ends.
      clear_producers();
      push_byte(1, 8'h11, 1'b1);
      wait_accept("mid_accept", 20);
      clear_producers();
      repeat (5) tick();
      chk("mid_state_wait_done", dbg_state, WAIT_DONE);
      push_byte(0, 8'hC0, 1'b1);
      push_byte(2, 8'hC2, 1'b1);
      push_byte(3, 8'hC3, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_tx_we", tx_we, 1'b0);
      chk("mid_rst_grant_id", grant_id, 0);
      chk("mid_rst_state", dbg_state, IDLE);
      chk("mid_busy_still_high", tx_busy, 1'b1);
      wait_accept("mid_post_accept", 200);
      chk("mid_post_winner", last_win, 0);
      chk("mid_post_busy_low", tx_busy, 1'b0);
      clear_producers();
      wait_idle("mid_idle", 300);

      // External frame already running: valid must wait.
      do_reset();
      busy_cnt = 30;
      tx_busy  = 1'b1;
      push_byte(2, 8'h62, 1'b1);
      repeat (10) tick();
      chk("ext_no_we", tx_we, 1'b0);
      chk("ext_no_ready", req_ready, '0);
      wait_accept("ext_accept", 100);
      chk("ext_winner", last_win, 2);
      chk("ext_busy_low", tx_busy, 1'b0);
      clear_producers();
      wait_idle("ext_idle", 300);

      // Packet: req1 sends three bytes (last on third) while req0 also has bytes.
      do_reset();
      frame_len = 3;
      sent_q.delete();
      push_byte(1, 8'hB0, 1'b0);
      push_byte(1, 8'hB1, 1'b0);
      push_byte(1, 8'hB2, 1'b1);
      push_byte(0, 8'hC0, 1'b1);
      push_byte(0, 8'hC1, 1'b1);
`ifdef UART_ARB_LOCK_EN
      exp_seq = '{8'hC0, 8'hB0, 8'hB1, 8'hB2, 8'hC1};
`else
      exp_seq = '{8'hC0, 8'hB0, 8'hC1, 8'hB1, 8'hB2};
`endif
      wait_sent("pkt_sent", 5, 200);
      wait_idle("pkt_idle", 50);
      for (int k = 0; k < 5; k++) begin
         if (k < sent_q.size()) chk("pkt_order", sent_q[k], exp_seq[k]);
      end
      chk("pkt_count", sent_q.size(), 5);

      // Randomized producers with legal valid drops and short frames.
      drop_en = 1'b1;
      for (int r = 0; r < 30; r++) begin
         clear_producers();
         frame_len = $urandom_range(1, 6);
         for (int i = 0; i < N; i++) begin
            int nb;
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) push_byte(i, W'($urandom), 1'($urandom_range(0, 1)));
         end
         ok = 1'b0;
         for (int c = 0; c < 400 && !ok; c++) begin
            tick();
            if (all_drained()) ok = 1'b1;
         end
         if (!ok) timeout_fail("rand_drain");
         wait_idle("rand_idle", 50);
         chk("rand_scoreboard_empty", exp_q.size(), 0);
      end
      drop_en = 1'b0;
      clear_producers();
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
